// File: rtl/ioctl_upload_reader_pkg.sv
// Shared types and constants for the ioctl upload (readback) path.
// Combinational only, no latency.
// No flow control of its own.
package ioctl_pkg;

  // Read engine states: waiting for a strobe, or waiting on the memory port.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } upl_state_t;

  localparam int         IOCTL_AW     = 25;
  localparam logic [7:0] DEFAULT_FILL = 8'hFF;

endpackage

// File: rtl/ioctl_upload_reader_if.sv
// Bundles the hps_io ioctl read side and the 16-bit word memory port.
// Wires only, no latency.
// The master (reader) holds mem_req until mem_ack and raises ioctl_wait while fetching.
interface ioctl_upload_reader_if
  import ioctl_pkg::*;
#(
  parameter int AW = 17
) ();

  logic                ioctl_upload;
  logic                ioctl_rd;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_din;
  logic                ioctl_wait;
  logic                mem_req;
  logic [AW-1:0]       mem_addr;
  logic                mem_ack;
  logic [15:0]         mem_data;
  logic                rd_err;

  modport master (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_data,
    output ioctl_din, ioctl_wait, mem_req, mem_addr, rd_err
  );

  modport slave (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_data,
    input  ioctl_din, ioctl_wait, mem_req, mem_addr, rd_err
  );

endinterface

// File: rtl/ioctl_upload_reader_word_cache.sv
// Single-entry cache of the last fetched 16-bit word and its word address.
// Hit is combinational from the lookup tag; load/invalidate take effect next cycle.
// No backpressure; invalidate wins over a simultaneous load.
module upl_word_cache
  import ioctl_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_inval,
  input  logic [AW-1:0] i_load_tag,
  input  logic [15:0]   i_load_data,
  input  logic [AW-1:0] i_lookup_tag,
  output logic          o_hit,
  output logic [15:0]   o_data
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [15:0]   r_data;

  // Hold the word of the most recent successful fetch.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= 16'h0000;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_load_tag;
      r_data  <= i_load_data;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

endmodule

// File: rtl/ioctl_upload_reader.sv
// Answers HPS upload read strobes with bytes fetched from a 16-bit word port.
// Window miss / cache hit: ioctl_din next cycle; miss: wait high until cycle after mem_ack.
// mem_req held until mem_ack or TIMEOUT; optional chk_sum under UPLOAD_CHECKSUM_EN.
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter int                  AW        = 17,
  parameter logic [IOCTL_AW-1:0] BASE_ADDR = 25'h0,
  parameter logic [IOCTL_AW-1:0] SIZE      = 25'h40000,
  parameter logic [7:0]          FILL      = DEFAULT_FILL,
  parameter int                  TIMEOUT   = 255
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  ioctl_upload_reader_if.master  bus
`ifdef UPLOAD_CHECKSUM_EN
  ,
  output logic [7:0]             chk_sum
`endif
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  upl_state_t          r_state, w_state_nxt;
  logic [7:0]          r_din, w_din_nxt;
  logic                r_wait, w_wait_nxt;
  logic                r_req, w_req_nxt;
  logic [AW-1:0]       r_addr, w_addr_nxt;
  logic [7:0]          r_tmo, w_tmo_nxt;
  logic                r_lane, w_lane_nxt;
  logic                r_drop, w_drop_nxt;
  logic                r_err, w_err_nxt;
  logic                r_upl_d;

  logic                w_upl_rise;
  logic [IOCTL_AW-1:0] w_off;
  logic                w_inwin;
  logic [AW-1:0]       w_word;
  logic                w_lane;
  logic                w_cache_hit;
  logic [15:0]         w_cache_data;
  logic                w_hit;
  logic                w_load;
  logic                w_inval;
  logic                w_din_upd;
  logic                w_discard;

  // Window decode: addresses below BASE_ADDR wrap to a huge offset and fall outside.
  assign w_upl_rise = bus.ioctl_upload & ~r_upl_d;
  assign w_off      = bus.ioctl_addr - BASE_ADDR;
  assign w_inwin    = (bus.ioctl_addr >= BASE_ADDR) && (w_off < SIZE);
  assign w_word     = w_off[AW:1];
  assign w_lane     = w_off[0];
  // A new session invalidates the cache this very cycle, so never trust a hit then.
  assign w_hit      = w_cache_hit & ~w_upl_rise;
  // Result of a fetch is thrown away once the session ended while it was in flight.
  assign w_discard  = r_drop | ~bus.ioctl_upload;

  upl_word_cache #(.AW(AW)) u_cache (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_load       (w_load),
    .i_inval      (w_inval),
    .i_load_tag   (r_addr),
    .i_load_data  (bus.mem_data),
    .i_lookup_tag (w_word),
    .o_hit        (w_cache_hit),
    .o_data       (w_cache_data)
  );

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath decisions for one strobe / one fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_din_nxt   = r_din;
    w_wait_nxt  = r_wait;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_tmo_nxt   = r_tmo;
    w_lane_nxt  = r_lane;
    w_drop_nxt  = r_drop;
    w_err_nxt   = w_upl_rise ? 1'b0 : r_err;
    w_load      = 1'b0;
    w_inval     = w_upl_rise;
    w_din_upd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ioctl_rd && bus.ioctl_upload) begin
          if (!w_inwin) begin
            w_din_nxt = FILL;
            w_din_upd = 1'b1;
          end else if (w_hit) begin
            w_din_nxt = w_lane ? w_cache_data[15:8] : w_cache_data[7:0];
            w_din_upd = 1'b1;
          end else begin
            w_state_nxt = FETCH;
            w_wait_nxt  = 1'b1;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = w_word;
            w_tmo_nxt   = 8'h00;
            w_lane_nxt  = w_lane;
            w_drop_nxt  = 1'b0;
          end
        end
      end
      FETCH: begin
        // Strobes arriving here are protocol violations and are simply ignored.
        w_tmo_nxt = r_tmo + 8'h01;
        if (!bus.ioctl_upload) w_drop_nxt = 1'b1;
        if (bus.mem_ack) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_wait_nxt  = 1'b0;
          if (!w_discard) begin
            w_load    = 1'b1;
            w_din_nxt = r_lane ? bus.mem_data[15:8] : bus.mem_data[7:0];
            w_din_upd = 1'b1;
          end
        end else if (r_tmo == TMO_LIM) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_wait_nxt  = 1'b0;
          if (!w_discard) begin
            w_din_nxt = FILL;
            w_din_upd = 1'b1;
            w_err_nxt = 1'b1;
            w_inval   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers; reset also withdraws any outstanding request.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_din   <= 8'h00;
      r_wait  <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_tmo   <= 8'h00;
      r_lane  <= 1'b0;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
      r_upl_d <= 1'b0;
    end else begin
      r_din   <= w_din_nxt;
      r_wait  <= w_wait_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_tmo   <= w_tmo_nxt;
      r_lane  <= w_lane_nxt;
      r_drop  <= w_drop_nxt;
      r_err   <= w_err_nxt;
      r_upl_d <= bus.ioctl_upload;
    end
  end

  assign bus.ioctl_din  = r_din;
  assign bus.ioctl_wait = r_wait;
  assign bus.mem_req    = r_req;
  assign bus.mem_addr   = r_addr;
  assign bus.rd_err     = r_err;

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] r_chk;
  logic [7:0] w_chk_base;

  assign w_chk_base = w_upl_rise ? 8'h00 : r_chk;

  // Running mod-256 sum of every byte placed on ioctl_din this session.
  always_ff @(posedge clk_sys) begin
    if (reset)          r_chk <= 8'h00;
    else if (w_din_upd) r_chk <= w_chk_base + w_din_nxt;
    else                r_chk <= w_chk_base;
  end

  assign chk_sum = r_chk;
`endif

endmodule
